shift_var_pipe: RTL and testbench

//  Pipelined, parametrised variable shifter: arithmetic/logical right, logical left, rotate right,

---
 rtl/shift_var_pipe.sv | 157 +++++++++++++++
 tb/tb_shift_var_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_var_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_var_pipe
// Description : Pipelined variable shifter (arith/logical right, logical left,
//               rotate right) with optional round-half-up on arithmetic right
//               shifts. One register stage per shift-amount bit plus an
//               output/round stage, global valid/ready stall.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_var_pipe #(
    parameter int WORD_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 4,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  data_in,
    input  logic [SHIFT_WIDTH-1:0] shift_amount,
    input  logic [1:0]             mode,
    input  logic                   round_en,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  data_out,
    output logic [TAG_WIDTH-1:0]   tag_out,
    output logic                   busy
);

    localparam logic [1:0] c_MODE_ASR = 2'b00;
    localparam logic [1:0] c_MODE_LSR = 2'b01;
    localparam logic [1:0] c_MODE_LSL = 2'b10;
    localparam logic [1:0] c_MODE_ROR = 2'b11;

    logic                   w_advance;
    logic                   w_round_in;
    logic [SHIFT_WIDTH-1:0] w_stage_vld;
    logic [SHIFT_WIDTH-1:0] w_unused_stage;
    logic                   r_out_valid;
    logic [WORD_WIDTH-1:0]  r_data_out;
    logic [TAG_WIDTH-1:0]   r_tag_out;

    // Whole pipe moves together; it only freezes when a result is stuck at the output.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Round bit is the last bit shifted out; it is only meaningful for 1..WORD_WIDTH-1.
    always_comb begin
        w_round_in = 1'b0;
        if (mode == c_MODE_ASR && round_en) begin
            for (int i = 0; i < WORD_WIDTH - 1; i++) begin
                if (int'(shift_amount) == i + 1) begin
                    w_round_in = data_in[i];
                end
            end
        end
    end

    for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
        localparam int c_DIST = 2 ** k;
        localparam int c_ROT  = c_DIST % WORD_WIDTH;

        logic [WORD_WIDTH-1:0]  w_src_data;
        logic [SHIFT_WIDTH-1:0] w_src_amt;
        logic [1:0]             w_src_mode;
        logic                   w_src_round;
        logic [TAG_WIDTH-1:0]   w_src_tag;
        logic                   w_src_vld;
        logic [WORD_WIDTH-1:0]  w_shifted;

        logic [WORD_WIDTH-1:0]  r_data;
        logic [SHIFT_WIDTH-1:0] r_amt;
        logic [1:0]             r_mode;
        logic                   r_round;
        logic [TAG_WIDTH-1:0]   r_tag;
        logic                   r_vld;

        if (k == 0) begin : g_src_port
            assign w_src_data  = data_in;
            assign w_src_amt   = shift_amount;
            assign w_src_mode  = mode;
            assign w_src_round = w_round_in;
            assign w_src_tag   = tag_in;
            assign w_src_vld   = in_valid;
        end else begin : g_src_prev
            assign w_src_data  = g_stage[k-1].r_data;
            assign w_src_amt   = g_stage[k-1].r_amt;
            assign w_src_mode  = g_stage[k-1].r_mode;
            assign w_src_round = g_stage[k-1].r_round;
            assign w_src_tag   = g_stage[k-1].r_tag;
            assign w_src_vld   = g_stage[k-1].r_vld;
        end

        // Shift by this stage's fixed distance when its amount bit is set; shifts past the
        // word width saturate naturally (sign fill / zero), rotate wraps modulo the width.
        always_comb begin
            w_shifted = w_src_data;
            if (w_src_amt[k]) begin
                case (w_src_mode)
                    c_MODE_ASR: w_shifted = $signed(w_src_data) >>> c_DIST;
                    c_MODE_LSR: w_shifted = w_src_data >> c_DIST;
                    c_MODE_LSL: w_shifted = w_src_data << c_DIST;
                    c_MODE_ROR: w_shifted = (w_src_data >> c_ROT) |
                                            (w_src_data << (WORD_WIDTH - c_ROT));
                    default:    w_shifted = w_src_data;
                endcase
            end
        end

        // Stage register: captures the shifted word and its sideband when the pipe advances.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld   <= 1'b0;
                r_data  <= '0;
                r_amt   <= '0;
                r_mode  <= '0;
                r_round <= 1'b0;
                r_tag   <= '0;
            end else if (w_advance) begin
                r_vld   <= w_src_vld;
                r_data  <= w_shifted;
                r_amt   <= w_src_amt;
                r_mode  <= w_src_mode;
                r_round <= w_src_round;
                r_tag   <= w_src_tag;
            end
        end

        assign w_stage_vld[k]    = r_vld;
        // Later stages read only the higher amount bits; the last stage reads neither field.
        assign w_unused_stage[k] = ^{r_amt, r_mode};
    end

    // Output stage: applies the round increment and holds the result until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_tag_out   <= '0;
        end else if (w_advance) begin
            r_out_valid <= g_stage[SHIFT_WIDTH-1].r_vld;
            if (g_stage[SHIFT_WIDTH-1].r_vld) begin
                r_data_out <= g_stage[SHIFT_WIDTH-1].r_data +
                              {{(WORD_WIDTH-1){1'b0}}, g_stage[SHIFT_WIDTH-1].r_round};
                r_tag_out  <= g_stage[SHIFT_WIDTH-1].r_tag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign tag_out   = r_tag_out;
    assign busy      = (|w_stage_vld) | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_shift_var_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_var_pipe
// Description : Directed self-checking bench for shift_var_pipe (W=16, S=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_var_pipe;

    localparam int WORD_WIDTH  = 16;
    localparam int SHIFT_WIDTH = 4;
    localparam int TAG_WIDTH   = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_WIDTH-1:0]  data_in;
    logic [SHIFT_WIDTH-1:0] shift_amount;
    logic [1:0]             mode;
    logic                   round_en;
    logic [TAG_WIDTH-1:0]   tag_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_WIDTH-1:0]  data_out;
    logic [TAG_WIDTH-1:0]   tag_out;
    logic                   busy;

    int n_checks;
    int n_fails;

    shift_var_pipe #(
        .WORD_WIDTH (WORD_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .shift_amount(shift_amount),
        .mode        (mode),
        .round_en    (round_en),
        .tag_in      (tag_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .tag_out     (tag_out),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One isolated beat: checks latency, result and tag.
    task automatic run_single(input string name, input logic [15:0] d, input logic [3:0] amt,
                              input logic [1:0] md, input logic rnd, input logic [15:0] exp);
        int lat;
        @(negedge clk);
        data_in      = d;
        shift_amount = amt;
        mode         = md;
        round_en     = rnd;
        tag_in       = amt;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, lat, SHIFT_WIDTH + 1);
        check({name, "_data"}, data_out, exp);
        check({name, "_tag"}, tag_out, amt);
    endtask

    logic [15:0] stall_exp [6];
    int          got;
    int          first_c;
    int          seen;

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        data_in      = '0;
        shift_amount = '0;
        mode         = '0;
        round_en     = 1'b0;
        tag_in       = '0;
        out_ready    = 1'b1;
        stall_exp    = '{16'h0400, 16'h0440, 16'h0480, 16'h04C0, 16'h0500, 16'h0540};

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        check("rst_tag_out", tag_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // Single-beat directed vectors
        run_single("asr_597_3",      16'd597,  4'd3,  2'b00, 1'b0, 16'd74);
        run_single("asr_597_3_rnd",  16'd597,  4'd3,  2'b00, 1'b1, 16'd75);
        run_single("asr_m597_3_rnd", 16'hFDAB, 4'd3,  2'b00, 1'b1, 16'hFFB5);
        run_single("lsr_m16_2",      16'hFFF0, 4'd2,  2'b01, 1'b0, 16'h3FFC);
        run_single("lsl_16_2",       16'd16,   4'd2,  2'b10, 1'b0, 16'd64);
        run_single("ror_1_1",        16'h0001, 4'd1,  2'b11, 1'b0, 16'h8000);
        run_single("ror_1234_4",     16'h1234, 4'd4,  2'b11, 1'b0, 16'h4123);
        run_single("ror_amt0",       16'hA5C3, 4'd0,  2'b11, 1'b0, 16'hA5C3);
        run_single("asr_amt0_rnd",   16'hA5C3, 4'd0,  2'b00, 1'b1, 16'hA5C3);
        run_single("asr_8000_15",    16'h8000, 4'd15, 2'b00, 1'b1, 16'hFFFF);
        run_single("asr_4000_15rnd", 16'h4000, 4'd15, 2'b00, 1'b1, 16'h0001);
        run_single("lsr_8000_15",    16'h8000, 4'd15, 2'b01, 1'b0, 16'h0001);
        run_single("lsl_0001_15",    16'h0001, 4'd15, 2'b10, 1'b0, 16'h8000);
        run_single("lsr_rnd_ignored",16'h0007, 4'd1,  2'b01, 1'b1, 16'h0003);

        // Back-to-back 8 beats, tags 0..7
        repeat (3) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    data_in      = 16'h0100 + 16'(i);
                    shift_amount = 4'd1;
                    mode         = 2'b10;
                    round_en     = 1'b0;
                    tag_in       = 4'(i);
                    in_valid     = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                got     = 0;
                first_c = -1;
                for (int c = 0; c < 40 && got < 8; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check("b2b_data", data_out, 16'h0200 + 16'(2 * got));
                        check("b2b_tag", tag_out, got);
                        if (first_c < 0) first_c = c;
                        else check("b2b_spacing", c, first_c + got);
                        got++;
                    end
                end
                check("b2b_count", got, 8);
            end
        join
        @(negedge clk);
        check("b2b_drained", out_valid, 0);

        // Full pipe stalled for 3 cycles, then released
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_fill_ready", in_ready, 1);
            data_in      = 16'h1000 + 16'(i * 256);
            shift_amount = 4'd2;
            mode         = 2'b01;
            tag_in       = 4'(8 + i);
            in_valid     = 1'b1;
        end
        @(negedge clk);
        data_in = 16'h1500;
        tag_in  = 4'd13;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_data_held", data_out, stall_exp[0]);
            check("stall_tag_held", tag_out, 8);
        end
        @(negedge clk);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            if (out_valid) begin
                check("stall_rel_data", data_out, stall_exp[got]);
                check("stall_rel_tag", tag_out, 8 + got);
                got++;
            end
        end
        check("stall_rel_count", got, 6);
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_no_dup", out_valid, 0);
        check("stall_idle_busy", busy, 0);

        // Reset with beats in flight
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            data_in      = 16'h0F00 + 16'(i);
            shift_amount = 4'd0;
            mode         = 2'b00;
            tag_in       = 4'(1 + i);
            in_valid     = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
        check("rstfly_out_valid_pre", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rstfly_out_valid", out_valid, 0);
        check("rstfly_busy", busy, 0);
        check("rstfly_data_out", data_out, 0);
        check("rstfly_tag_out", tag_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rstfly_in_ready", in_ready, 1);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("rstfly_no_stale", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
